// File: rtl/scm_write_port_arbiter_pkg.sv
// Shared definitions for the SCM register-file controllers.
//   state_e   : controller FSM states (INIT sweep, ARB normal arbitration)
//   idx_width : width of an index able to address n items (min 1 bit)
package scm_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/scm_write_port_arbiter_rr.sv
// scm_rr_arbiter: round-robin arbiter, N requests -> one-hot grant + index.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req_i      : request vector
//   ready_i    : grant is consumed this cycle; pointer moves only on valid & ready
//   gnt_o      : one-hot grant (combinational, same cycle as request)
//   idx_o      : binary index of the granted request
//   valid_o    : at least one request is asserted
module scm_rr_arbiter
    import scm_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found_s;
    int unsigned   cand_s;

    // Search from the priority pointer upward, wrapping, and take the first request.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_s = (32'(ptr_q) + i) % N;
            if (!found_s && req_i[cand_s[IW-1:0]]) begin
                found_s               = 1'b1;
                gnt_o[cand_s[IW-1:0]] = 1'b1;
                idx_o                 = cand_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        valid_o = found_s;
    end

    // Next pointer: one past the winner when the grant is consumed, otherwise hold.
    always_comb begin
        if (found_s && ready_i) begin
            if (idx_o == IW'(N - 32'd1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scm_write_port_arbiter.sv
// scm_write_port_arbiter: write-port arbiter / controller for the multi-way
// latch-based register file (one write port, N_READ read ports).
// Optional feature macro: SCM_WARB_INIT_EN -- when defined, reset enters an INIT
// sweep that clears every word of every way before traffic is accepted.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   wr_req_i / wr_gnt_o         : per-requester write valid / one-hot grant
//   wr_way_i/addr_i/data_i      : per-requester way mask, word address, data (flattened)
//   rd_req_i / rd_addr_i        : per-port read request / address (flattened)
//   rd_gnt_o                    : read accepted (masked on collision with the write)
//   WriteEnable/Addr/Data/Way   : register file write port (WriteWay lags by one cycle)
//   ReadEnable / ReadAddr       : register file read ports
//   init_done_o                 : controller accepts traffic
module scm_write_port_arbiter
    import scm_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned NB_WAYS    = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               wr_req_i,
    output logic [N_REQ-1:0]               wr_gnt_o,
    input  logic [N_REQ*NB_WAYS-1:0]       wr_way_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]    wr_data_i,
    input  logic [N_READ-1:0]              rd_req_i,
    input  logic [N_READ*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [N_READ-1:0]              rd_gnt_o,
    output logic                           WriteEnable,
    output logic [ADDR_WIDTH-1:0]          WriteAddr,
    output logic [DATA_WIDTH-1:0]          WriteData,
    output logic [NB_WAYS-1:0]             WriteWay,
    output logic [N_READ-1:0]              ReadEnable,
    output logic [N_READ*ADDR_WIDTH-1:0]   ReadAddr,
    output logic                           init_done_o
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
`ifdef SCM_WARB_INIT_EN
    localparam state_e RESET_STATE = INIT;
`else
    localparam state_e RESET_STATE = ARB;
`endif

    state_e                state_q;
    state_e                state_d;
    logic [NB_WAYS-1:0]    way_q;
    logic [NB_WAYS-1:0]    way_d;
    logic                  init_done_q;
    logic                  arb_active_s;
    logic                  arb_write_s;
    logic [N_REQ-1:0]      raw_gnt_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic                  any_req_s;
    logic                  we_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [N_READ-1:0]     rd_gnt_s;

    // init_done_q also blocks grants in the cycles right after a reset edge.
    assign arb_active_s = (state_q == ARB) && init_done_q;
    assign arb_write_s  = arb_active_s && any_req_s;

    scm_rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   (wr_req_i),
        .ready_i (arb_active_s),
        .gnt_o   (raw_gnt_s),
        .idx_o   (gnt_idx_s),
        .valid_o (any_req_s)
    );

`ifdef SCM_WARB_INIT_EN
    logic [ADDR_WIDTH-1:0] cnt_q;

    // Sweep counter: steps once per INIT cycle; leaves INIT on the last word, so it never wraps in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end
`endif

    // Next state and write-port drive (sweep writes in INIT, granted requester in ARB).
    always_comb begin
        state_d = state_q;
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = '0;
        way_d   = '0;
        case (state_q)
            INIT: begin
`ifdef SCM_WARB_INIT_EN
                we_s    = 1'b1;
                waddr_s = cnt_q;
                way_d   = '1;
                if (&cnt_q) begin
                    state_d = ARB;
                end else begin
                    state_d = INIT;
                end
`else
                state_d = ARB;
`endif
            end
            ARB: begin
                state_d = ARB;
                if (arb_write_s) begin
                    we_s    = 1'b1;
                    waddr_s = wr_addr_i[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_s = wr_data_i[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    way_d   = wr_way_i[gnt_idx_s*NB_WAYS +: NB_WAYS];
                end else begin
                    we_s    = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Read hazard: a read of the word being written this cycle waits one cycle.
    always_comb begin
        rd_gnt_s = '0;
        for (int unsigned p = 0; p < N_READ; p++) begin
            if (arb_active_s && rd_req_i[p] &&
                !(we_s && (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == waddr_s))) begin
                rd_gnt_s[p] = 1'b1;
            end else begin
                rd_gnt_s[p] = 1'b0;
            end
        end
    end

    // State, lagged way mask (zero after an idle cycle) and init-done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            way_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            way_q       <= way_d;
            init_done_q <= (state_d == ARB);
        end
    end

    assign wr_gnt_o    = arb_active_s ? raw_gnt_s : '0;
    assign rd_gnt_o    = rd_gnt_s;
    assign WriteEnable = we_s;
    assign WriteAddr   = waddr_s;
    assign WriteData   = wdata_s;
    assign WriteWay    = way_q;
    assign ReadEnable  = rd_gnt_s;
    assign ReadAddr    = rd_addr_i;
    assign init_done_o = init_done_q;

endmodule
